edf_queue_arbiter: RTL and testbench
====================================

// Module: edf_queue_arbiter
// PURPOSE
//  Earliest-Deadline-First arbiter over NB_CORES per-core request queues (1-cycle-read BRAM FIFOs).
//  Sits between the per-core queues and the single downstream memory port.
//  Tracks a remaining-deadline countdown per queue head, grants the non-empty queue with the smallest
//  remaining deadline, forwards its head entry downstream and pops it with a 1-cycle consume pulse.
// PARAMETERS
//  NB_CORES       4   number of queues arbitrated (>=2)
//  DATA_SIZE      8   width of one queue entry
//  REGISTER_SIZE  32  width of deadline registers and countdowns
// PORTS
//  clock          in   1                        system clock
//  reset          in   1                        asynchronous, active-high reset
//  enable         in   1                        0: no new grants (grant in progress completes)
//  deadlines      in   NB_CORES*REGISTER_SIZE   relative deadline per core, core i at [i*RS +: RS]
//  queue_empty    in   NB_CORES                 empty flag of each queue
//  queue_data     in   NB_CORES*DATA_SIZE       head entry (valueOut) of each queue
//  consumed       out  NB_CORES                 one-hot 1-cycle pop pulse to the granted queue
//  out_data       out  DATA_SIZE                granted entry
//  out_valid      out  1                        out_data valid
//  out_ready      in   1                        downstream accepts when out_valid & out_ready
//  grant_id       out  $clog2(NB_CORES)         index of queue being served
//  miss_count     out  REGISTER_SIZE            deadline-miss counter (MISS_COUNTER_EN only)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, consumed=0, out_valid=0, out_data=0, grant_id=0, all countdowns=0,
//   all armed flags=0, miss_count=0. Reset mid-transfer drops the transfer; no consume pulse issued.
//  Countdown per core i (every cycle, independent of FSM):
//   - !armed[i] & !queue_empty[i]: load deadlines[i], armed[i]<=1.
//   - armed[i]: decrement, saturate at 0 (never wraps).
//   - consumed[i] pulse: armed[i]<=0 (re-arms from next head after SETTLE).
//   - queue_empty[i] & !consumed[i]: armed[i]<=0.
//  Selection (combinational, IDLE only): among cores with !queue_empty & armed, minimum countdown;
//   ties -> lowest index. Unsigned compare, full REGISTER_SIZE width. deadlines[i]=0 = always urgent.
//  FSM:
//   IDLE   : enable & any eligible -> latch winner into grant_id, out_data<=queue_data[winner],
//            out_valid<=1, go SEND. Else stay.
//   SEND   : hold out_data/grant_id stable while out_valid. out_valid & out_ready -> out_valid<=0,
//            consumed[grant_id]<=1 for exactly one cycle, go SETTLE. No timeout.
//   SETTLE : consumed<=0; wait one cycle so queue head pointer and BRAM output refresh; go IDLE.
//  Latency: eligible head -> out_valid = 1 cycle; throughput max 1 entry / 3 cycles.
//  A new arrival with an earlier deadline never pre-empts an entry already in SEND.
//  enable deassertion in SEND/SETTLE does not abort; takes effect in IDLE.
//  Only one consumed bit ever high; never pulsed for an empty queue.
// CONFIGURATION
//  MISS_COUNTER_EN defined: miss_count increments (saturating at all-ones) on each handshake where
//   the granted core's countdown is 0 at the handshake cycle.
//  MISS_COUNTER_EN undefined: no counter logic; miss_count tied to 0.
// TESTING
//  1. Reset held, then released with all empty -> out_valid=0, consumed=0 for 20 cycles.
//  2. deadlines={40,30,20,10}, all 4 queues non-empty same cycle, out_ready=1 ->
//     grant order 3,2,1,0; each consumed pulse exactly 1 cycle, grants 3 cycles apart.
//  3. Tie: deadlines all 16, queues 1 and 2 fill same cycle -> grant_id=1 first, then 2.
//  4. Backpressure: out_ready=0 for 10 cycles in SEND -> out_data/grant_id stable, no consumed;
//     out_ready=1 -> one consumed pulse, next cycle consumed=0.
//  5. Saturation: deadlines[0]=3, out_ready=0 for 8 cycles -> countdown holds 0, no wrap;
//     with MISS_COUNTER_EN, miss_count=1 after handshake; without, miss_count=0.
//  6. Async reset asserted mid-SEND -> out_valid and consumed drop immediately,
//     countdowns=0; after release arbitration restarts from IDLE.

Source files
------------

// File: rtl/edf_queue_arbiter.sv
// Earliest-Deadline-First arbiter: grants the non-empty, armed queue head with the smallest remaining deadline.
// Optional deadline-miss counter built only when MISS_COUNTER_EN is defined (otherwise miss_count is tied to 0).
module edf_queue_arbiter #(
  parameter int NB_CORES      = 4,
  parameter int DATA_SIZE     = 8,
  parameter int REGISTER_SIZE = 32,
  localparam int ID_W         = $clog2(NB_CORES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NB_CORES*REGISTER_SIZE-1:0] deadlines,
  input  logic [NB_CORES-1:0]               queue_empty,
  input  logic [NB_CORES*DATA_SIZE-1:0]     queue_data,
  output logic [NB_CORES-1:0]               consumed,
  output logic [DATA_SIZE-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ID_W-1:0]                   grant_id,
  output logic [REGISTER_SIZE-1:0]          miss_count
);

  typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

  state_t                   state_q;
  logic [NB_CORES-1:0]      consumed_q;
  logic [DATA_SIZE-1:0]     out_data_q;
  logic                     out_valid_q;
  logic [ID_W-1:0]          grant_q;
  logic [REGISTER_SIZE-1:0] cnt_q   [NB_CORES];
  logic [REGISTER_SIZE-1:0] cnt_d   [NB_CORES];
  logic [NB_CORES-1:0]      armed_q;
  logic [NB_CORES-1:0]      armed_d;

  logic [REGISTER_SIZE-1:0] dl      [NB_CORES];
  logic [DATA_SIZE-1:0]     qd      [NB_CORES];

  logic                     any_elig;
  logic [ID_W-1:0]          win_idx;
  logic [REGISTER_SIZE-1:0] win_cnt;
  logic                     handshake;

  for (genvar g = 0; g < NB_CORES; g++) begin : g_unpack
    assign dl[g] = deadlines[g*REGISTER_SIZE +: REGISTER_SIZE];
    assign qd[g] = queue_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // Countdown re-arms from the new head once the old head has been popped or the queue drains.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    for (int i = 0; i < NB_CORES; i++) begin
      if (!armed_q[i]) begin
        if (!queue_empty[i]) begin
          cnt_d[i]   = dl[i];
          armed_d[i] = 1'b1;
        end
      end else begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - REGISTER_SIZE'(1);
        if (consumed_q[i] || queue_empty[i]) armed_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB_CORES; i++) cnt_q[i] <= '0;
      armed_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // Strict less-than keeps the lowest index on equal countdowns.
  always_comb begin
    any_elig = 1'b0;
    win_idx  = '0;
    win_cnt  = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (!queue_empty[i] && armed_q[i] && (!any_elig || cnt_q[i] < win_cnt)) begin
        any_elig = 1'b1;
        win_idx  = ID_W'(i);
        win_cnt  = cnt_q[i];
      end
    end
  end

  assign handshake = (state_q == SEND) && out_valid_q && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      consumed_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          consumed_q <= '0;
          if (enable && any_elig) begin
            grant_q     <= win_idx;
            out_data_q  <= qd[win_idx];
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            consumed_q  <= {{(NB_CORES-1){1'b0}}, 1'b1} << grant_q;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          // One idle cycle lets the popped FIFO present its next head.
          consumed_q <= '0;
          state_q    <= IDLE;
        end
        default: begin
          consumed_q  <= '0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef MISS_COUNTER_EN
  logic [REGISTER_SIZE-1:0] miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
    end else if (handshake && cnt_q[grant_q] == '0 && miss_q != '1) begin
      miss_q <= miss_q + REGISTER_SIZE'(1);
    end
  end

  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

  assign consumed  = consumed_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_edf_queue_arbiter.sv
// Directed bench for edf_queue_arbiter with a small per-queue FIFO model driven from the consume pulses.
module tb_edf_queue_arbiter;
  localparam int NB = 4;
  localparam int DS = 8;
  localparam int RS = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable;
  logic [NB*RS-1:0]  deadlines;
  logic [NB-1:0]     queue_empty;
  logic [NB*DS-1:0]  queue_data;
  logic [NB-1:0]     consumed;
  logic [DS-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        grant_id;
  logic [RS-1:0]     miss_count;

  int vectors     = 0;
  int miscompares = 0;
  int qcnt  [NB];
  logic [DS-1:0] qhead [NB];

  edf_queue_arbiter #(.NB_CORES(NB), .DATA_SIZE(DS), .REGISTER_SIZE(RS)) dut (
    .clock(clock), .reset(reset), .enable(enable), .deadlines(deadlines),
    .queue_empty(queue_empty), .queue_data(queue_data), .consumed(consumed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

`ifdef MISS_COUNTER_EN
  localparam int MISS_ON = 1;
`else
  localparam int MISS_ON = 0;
`endif

  task automatic drive_q();
    for (int i = 0; i < NB; i++) begin
      queue_empty[i] = (qcnt[i] == 0);
      queue_data[i*DS +: DS] = qhead[i];
    end
  endtask

  task automatic push(input int i, input logic [DS-1:0] d);
    qcnt[i]  = 1;
    qhead[i] = d;
    drive_q();
  endtask

  task automatic set_dl(input int i, input int v);
    deadlines[i*RS +: RS] = RS'(v);
  endtask

  // Advance one clock; a consume pulse seen before the edge pops the modelled FIFO at that edge.
  task automatic step();
    logic [NB-1:0] c;
    c = consumed;
    @(posedge clock);
    #1;
    for (int i = 0; i < NB; i++) begin
      if (c[i]) begin
        vectors++;
        if (qcnt[i] == 0) begin
          miscompares++;
          $display("FAIL pop_nonempty core%0d: got pop of empty queue, required non-empty", i);
        end else begin
          qcnt[i]--;
          qhead[i] = qhead[i] + 8'd1;
        end
      end
    end
    drive_q();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; out_ready = 1'b0; deadlines = '0;
    for (int i = 0; i < NB; i++) begin qcnt[i] = 0; qhead[i] = '0; end
    drive_q();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; deadlines = '0;
    for (int i = 0; i < NB; i++) begin qcnt[i] = 0; qhead[i] = '0; end
    drive_q();
    repeat (3) @(posedge clock);
    #1;
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL rst_consumed: got %b required 0000", consumed); end
    if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h required 00", out_data); end
    if (miss_count !== 32'd0) begin miscompares++; $display("FAIL rst_miss: got %0d required 0", miss_count); end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid cyc%0d: got %b required 0", k, out_valid); end
      if (consumed !== 4'b0) begin miscompares++; $display("FAIL idle_consumed cyc%0d: got %b required 0000", k, consumed); end
    end
  endtask

  task automatic test_edf_order();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin set_dl(i, 40 - 10*i); push(i, 8'hA0 + 8'(i)); end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL edf_arm_valid: got %b required 0", out_valid); end
    for (int g = 3; g >= 0; g--) begin
      step();
      vectors += 3;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL edf_valid g%0d: got %b required 1", g, out_valid); end
      if (grant_id !== 2'(g)) begin miscompares++; $display("FAIL edf_grant: got %0d required %0d", grant_id, g); end
      if (out_data !== 8'hA0 + 8'(g)) begin miscompares++; $display("FAIL edf_data g%0d: got %h required %h", g, out_data, 8'hA0 + 8'(g)); end
      step();
      vectors += 2;
      if (consumed !== 4'(1 << g)) begin miscompares++; $display("FAIL edf_pulse g%0d: got %b required %b", g, consumed, 4'(1 << g)); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL edf_valid_drop g%0d: got %b required 0", g, out_valid); end
      step();
      vectors++;
      if (consumed !== 4'b0) begin miscompares++; $display("FAIL edf_pulse_len g%0d: got %b required 0000", g, consumed); end
    end
  endtask

  task automatic test_tie();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) set_dl(i, 16);
    push(1, 8'hB1);
    push(2, 8'hB2);
    step();
    for (int g = 1; g <= 2; g++) begin
      step();
      vectors += 2;
      if (grant_id !== 2'(g)) begin miscompares++; $display("FAIL tie_grant: got %0d required %0d", grant_id, g); end
      if (out_data !== 8'hB0 + 8'(g)) begin miscompares++; $display("FAIL tie_data: got %h required %h", out_data, 8'hB0 + 8'(g)); end
      step();
      vectors++;
      if (consumed !== 4'(1 << g)) begin miscompares++; $display("FAIL tie_pulse: got %b required %b", consumed, 4'(1 << g)); end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_dl(0, 16);
    push(0, 8'hC0);
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b required 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      step();
      vectors += 4;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cyc%0d: got %b required 1", k, out_valid); end
      if (out_data !== 8'hC0) begin miscompares++; $display("FAIL bp_hold_data cyc%0d: got %h required c0", k, out_data); end
      if (grant_id !== 2'd0) begin miscompares++; $display("FAIL bp_hold_grant cyc%0d: got %0d required 0", k, grant_id); end
      if (consumed !== 4'b0) begin miscompares++; $display("FAIL bp_no_pulse cyc%0d: got %b required 0000", k, consumed); end
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (consumed !== 4'b0001) begin miscompares++; $display("FAIL bp_pulse: got %b required 0001", consumed); end
    step();
    vectors += 2;
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL bp_pulse_len: got %b required 0000", consumed); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b required 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_dl(0, 3);
    push(0, 8'h5A);
    step();
    step();
    repeat (8) step();
    out_ready = 1'b1;
    step();
    step();
    vectors += 2;
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL sat_pulse_len: got %b required 0000", consumed); end
    if (miss_count !== RS'(MISS_ON)) begin miscompares++; $display("FAIL sat_miss: got %0d required %0d", miss_count, MISS_ON); end
  endtask

  // Core 0 sits at zero for many cycles while core 1 still counts; a wrapped countdown would lose to core 1.
  task automatic test_no_wrap();
    do_reset();
    set_dl(0, 3); set_dl(1, 20); set_dl(2, 0);
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12);
    step();
    step();
    vectors++;
    if (grant_id !== 2'd2) begin miscompares++; $display("FAIL wrap_first: got %0d required 2", grant_id); end
    repeat (10) step();
    out_ready = 1'b1;
    step();
    vectors++;
    if (miss_count !== RS'(MISS_ON)) begin miscompares++; $display("FAIL wrap_miss1: got %0d required %0d", miss_count, MISS_ON); end
    step();
    step();
    vectors++;
    if (grant_id !== 2'd0) begin miscompares++; $display("FAIL wrap_second: got %0d required 0", grant_id); end
    step();
    step();
    step();
    vectors++;
    if (grant_id !== 2'd1) begin miscompares++; $display("FAIL wrap_third: got %0d required 1", grant_id); end
    step();
    vectors++;
    if (miss_count !== RS'(2*MISS_ON)) begin miscompares++; $display("FAIL wrap_miss_total: got %0d required %0d", miss_count, 2*MISS_ON); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    out_ready = 1'b1;
    set_dl(3, 8);
    push(3, 8'hD3);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL en_blocked cyc%0d: got %b required 0", k, out_valid); end
    end
    enable = 1'b1;
    step();
    vectors += 2;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL en_grant: got %b required 1", out_valid); end
    if (grant_id !== 2'd3) begin miscompares++; $display("FAIL en_grant_id: got %0d required 3", grant_id); end
    enable = 1'b0;
    step();
    vectors++;
    if (consumed !== 4'b1000) begin miscompares++; $display("FAIL en_no_abort: got %b required 1000", consumed); end
    step();
    vectors++;
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL en_pulse_len: got %b required 0000", consumed); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_dl(2, 12);
    push(2, 8'hE2);
    step();
    step();
    vectors++;
    if (grant_id !== 2'd2) begin miscompares++; $display("FAIL ar_pre_grant: got %0d required 2", grant_id); end
    #2 reset = 1'b1;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid_drop: got %b required 0", out_valid); end
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL ar_consumed: got %b required 0000", consumed); end
    if (grant_id !== 2'd0) begin miscompares++; $display("FAIL ar_grant_clr: got %0d required 0", grant_id); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL ar_data_clr: got %h required 00", out_data); end
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_rearm: got %b required 0", out_valid); end
    step();
    vectors++;
    if (out_valid !== 1'b1 || grant_id !== 2'd2) begin miscompares++; $display("FAIL ar_restart: got valid=%b id=%0d required valid=1 id=2", out_valid, grant_id); end
    out_ready = 1'b1;
    step();
    vectors++;
    if (consumed !== 4'b0100) begin miscompares++; $display("FAIL ar_pulse: got %b required 0100", consumed); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (consumed !== 4'b0) begin miscompares++; $display("FAIL ar_pulse_drop: got %b required 0000", consumed); end
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hE2) begin miscompares++; $display("FAIL ar_entry_kept: got valid=%b data=%h required valid=1 data=e2", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_edf_order();
    test_tie();
    test_backpressure();
    test_saturation();
    test_no_wrap();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
